// File: rtl/delay_arb_pkg.sv
// Shared types, default sizing and the delay clamp used by delay_arbiter.
package delay_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_N     = 200000;
  localparam int DEF_CBITS = 18;

  // A zero request still occupies the counter for one cycle; oversize requests saturate at n.
  function automatic logic [31:0] clamp_dly(input logic [31:0] d, input logic [31:0] n);
    logic [31:0] r;
    r = d;
    if (d == 32'd0) begin
      r = 32'd1;
    end else if (d > n) begin
      r = n;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_arbiter_if.sv
// Requester-side bundle of delay_arbiter: request/delay in, grant/done/status out.
interface delay_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CBITS = 18
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] dly;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  err;

  modport master (output req, dly, input gnt, done, busy, err);
  modport slave  (input req, dly, output gnt, done, busy, err);
endinterface

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req after 'last', with wrap.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int LBITS = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [LBITS-1:0] last,
  output logic [NREQ-1:0]  pick,
  output logic [LBITS-1:0] idx,
  output logic             any
);

  // Scan from last+1 upward; the first hit wins and later hits are masked by 'any'.
  always_comb begin
    int  j;
    logic hit;
    j    = 0;
    hit  = 1'b0;
    pick = {NREQ{1'b0}};
    idx  = {LBITS{1'b0}};
    any  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j       = (int'(last) + k) % NREQ;
      hit     = !any && req[j];
      pick[j] = pick[j] | hit;
      idx     = hit ? LBITS'(j) : idx;
      any     = any | req[j];
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Shared delay-timer scheduler: one counter, round-robin among NREQ requesters.
// Optional feature: define DELAY_ARB_ABORT_EN to abort a delay when its req drops.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int N     = DEF_N,
  parameter int CBITS = DEF_CBITS
) (
  input logic             clk,
  input logic             rst,
  delay_arbiter_if.slave  bus
);

  localparam int LBITS = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
  localparam logic [CBITS-1:0] CNT_ZERO = {CBITS{1'b0}};
  localparam logic [NREQ-1:0]  REQ_ZERO = {NREQ{1'b0}};
  localparam logic [LBITS-1:0] LAST_RST = LBITS'(NREQ - 1);

  state_t           state_r;
  logic [CBITS-1:0] cnt_r;
  logic [CBITS-1:0] len_r;
  logic [LBITS-1:0] last_r;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  done_r;
  logic             busy_r;
  logic             err_r;

  logic [NREQ-1:0]  pick_s;
  logic [LBITS-1:0] idx_s;
  logic             any_s;
  logic [CBITS-1:0] dly_sel_s;
  logic [CBITS-1:0] len_s;
  logic             over_s;
  logic             finish_s;

  rr_pick #(.NREQ(NREQ), .LBITS(LBITS)) u_pick (
    .req  (bus.req),
    .last (last_r),
    .pick (pick_s),
    .idx  (idx_s),
    .any  (any_s)
  );

  assign dly_sel_s = bus.dly[idx_s*CBITS +: CBITS];
  assign len_s     = CBITS'(clamp_dly(32'(dly_sel_s), 32'(N)));
  assign over_s    = 32'(dly_sel_s) > 32'(N);

`ifdef DELAY_ARB_ABORT_EN
  // A dropped req in the done cycle changes nothing: that edge ends the grant anyway.
  assign finish_s = (cnt_r == len_r) || !(|(bus.req & gnt_r));
`else
  assign finish_s = (cnt_r == len_r);
`endif

  // Scheduler FSM, shared counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      len_r   <= CNT_ZERO;
      last_r  <= LAST_RST;
      gnt_r   <= REQ_ZERO;
      done_r  <= REQ_ZERO;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            len_r   <= len_s;
            cnt_r   <= CNT_ONE;
            gnt_r   <= pick_s;
            done_r  <= (len_s == CNT_ONE) ? pick_s : REQ_ZERO;
            busy_r  <= 1'b1;
            last_r  <= idx_s;
            err_r   <= err_r | over_s;
            state_r <= RUN;
          end else begin
            cnt_r   <= CNT_ZERO;
            gnt_r   <= REQ_ZERO;
            done_r  <= REQ_ZERO;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (finish_s) begin
            cnt_r   <= CNT_ZERO;
            gnt_r   <= REQ_ZERO;
            done_r  <= REQ_ZERO;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            done_r  <= ((cnt_r + CNT_ONE) == len_r) ? gnt_r : REQ_ZERO;
            state_r <= RUN;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          gnt_r   <= REQ_ZERO;
          done_r  <= REQ_ZERO;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter (NREQ=4, N=10, CBITS=4); honours DELAY_ARB_ABORT_EN.
module tb_delay_arbiter;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  delay_arbiter_if #(.NREQ(4), .CBITS(4)) bus ();

  delay_arbiter #(.NREQ(4), .N(10), .CBITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got gnt/done/busy/err=%b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk_dly(input logic [3:0] d0, input logic [3:0] d1,
                                         input logic [3:0] d2, input logic [3:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Drive one cycle of inputs and queue the outputs required after the next rising edge.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic [15:0] d,
                     input logic [3:0] eg, input logic [3:0] ed, input logic eb,
                     input logic ee, input string tag);
    @(negedge clk);
    #1;
    rst     = r;
    bus.req = rq;
    bus.dly = d;
    exp_q.push_back({eg, ed, eb, ee});
    tag_q.push_back(tag);
  endtask

  // One complete grant of length len to requester i, followed by its mandatory idle cycle.
  task automatic serve(input int i, input int len, input logic [3:0] rq, input logic [15:0] d,
                       input logic ee, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    for (int k = 1; k <= len; k++) begin
      cyc(1'b0, rq, d, oh, (k == len) ? oh : 4'b0000, 1'b1, ee, tag);
    end
    cyc(1'b0, rq, d, 4'b0000, 4'b0000, 1'b0, ee, {tag, "_end"});
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    string      t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {bus.gnt, bus.done, bus.busy, bus.err}, e);
    end
  end

  initial begin
    logic [15:0] d;
    chk_cnt  = 0;
    pass_cnt = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.dly  = 16'h0000;

    cyc(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "reset");
    cyc(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "reset");
    cyc(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "idle");

    // Single requester, L=3.
    d = mk_dly(4'd0, 4'd0, 4'd3, 4'd0);
    serve(2, 3, 4'b0100, d, 1'b0, "single");
    cyc(1'b0, 4'b0000, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "single_idle");

    // Contention after reset: rotating order 0,1,2,3,0 with L=1.
    cyc(1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "rst2");
    d = mk_dly(4'd1, 4'd1, 4'd1, 4'd1);
    for (int g = 0; g < 5; g++) begin
      serve(g % 4, 1, 4'b1111, d, 1'b0, "rr");
    end
    cyc(1'b0, 4'b0000, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "rr_idle");

    // Clamping: oversize saturates at 10 and latches err; zero becomes one.
    d = mk_dly(4'd0, 4'd15, 4'd0, 4'd0);
    serve(1, 10, 4'b0010, d, 1'b1, "clamp15");
    cyc(1'b0, 4'b0000, d, 4'b0000, 4'b0000, 1'b0, 1'b1, "err_sticky");
    d = mk_dly(4'd0, 4'd0, 4'd0, 4'd0);
    serve(1, 1, 4'b0010, d, 1'b1, "clamp0");
    cyc(1'b0, 4'b0000, d, 4'b0000, 4'b0000, 1'b0, 1'b1, "err_sticky2");
    cyc(1'b1, 4'b0000, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "err_clear");

    // Reset on the 4th grant cycle of an L=8 delay, then priority restarts at 0.
    d = mk_dly(4'd8, 4'd0, 4'd0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 4'b0001, d, 4'b0001, 4'b0000, 1'b1, 1'b0, "rst_mid_run");
    end
    cyc(1'b1, 4'b0001, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "rst_mid");
    d = mk_dly(4'd1, 4'd1, 4'd0, 4'd0);
    serve(0, 1, 4'b0011, d, 1'b0, "post_rst_first");
    serve(1, 1, 4'b0011, d, 1'b0, "post_rst_second");
    cyc(1'b0, 4'b0000, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "post_rst_idle");

    // Requester 3 (L=6) drops req on its 2nd grant cycle while req[0] waits.
    d = mk_dly(4'd1, 4'd0, 4'd0, 4'd6);
    cyc(1'b0, 4'b1001, d, 4'b1000, 4'b0000, 1'b1, 1'b0, "drop_run");
    cyc(1'b0, 4'b1001, d, 4'b1000, 4'b0000, 1'b1, 1'b0, "drop_run");
`ifdef DELAY_ARB_ABORT_EN
    cyc(1'b0, 4'b0001, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "abort");
`else
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 4'b0001, d, 4'b1000, 4'b0000, 1'b1, 1'b0, "full_run");
    end
    cyc(1'b0, 4'b0001, d, 4'b1000, 4'b1000, 1'b1, 1'b0, "full_done");
    cyc(1'b0, 4'b0001, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "full_end");
`endif
    serve(0, 1, 4'b0001, d, 1'b0, "pending0");
    cyc(1'b0, 4'b0000, d, 4'b0000, 4'b0000, 1'b0, 1'b0, "final_idle");

    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("drain", 10'(exp_q.size()), 10'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
